// File: rtl/uniform_f32_multi_gen.sv
// Multi-channel uniform random generator: one 23-bit Fibonacci LFSR (x^23+x^18+1) per channel.
// Samples are emitted as floats in [1,2) or raw mantissas behind a valid/ready output register.

module uniform_f32_lane #(
  parameter int unsigned STEPS   = 1,
  parameter logic [22:0] RST_VAL = 23'h000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_en_i,
  input  logic        seed_en_i,
  input  logic [22:0] seed_data_i,
  output logic [22:0] state_o
);
  logic [22:0] state_q, state_d, adv;

  // STEPS shifts unrolled into one combinational cone
  always_comb begin
    adv = state_q;
    for (int k = 0; k < int'(STEPS); k++) adv = {adv[21:0], adv[22] ^ adv[17]};
  end

  always_comb begin
    state_d = state_q;
    if (seed_en_i)     state_d = (seed_data_i == 23'd0) ? 23'h000001 : seed_data_i;
    else if (adv_en_i) state_d = adv;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= RST_VAL;
    else     state_q <= state_d;

  assign state_o = state_q;
endmodule

module uniform_f32_multi_gen #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned STEPS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              mode,
  input  logic              seed_wr,
  input  logic [2:0]        seed_ch,
  input  logic [22:0]       seed_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NCH-1:0] out_data,
  output logic [31:0]       sample_cnt
);
  logic                      load, hs;
  logic                      out_valid_q, out_valid_d;
  logic [NCH-1:0][31:0]      out_data_q, out_data_d;
  logic [31:0]               sample_cnt_q, sample_cnt_d;
  logic [NCH-1:0][22:0]      state;
  logic [8:0]                prefix;

  assign load   = run && !seed_wr && (!out_valid_q || out_ready);
  assign hs     = out_valid_q && out_ready;
  assign prefix = mode ? 9'h000 : 9'h07F;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    uniform_f32_lane #(
      .STEPS  (STEPS),
      .RST_VAL(23'h000001 << i)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .adv_en_i   (load),
      .seed_en_i  (seed_wr && (seed_ch == 3'(i))),
      .seed_data_i(seed_data),
      .state_o    (state[i])
    );
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    sample_cnt_d = sample_cnt_q + {31'd0, hs};
    if (load) begin
      for (int i = 0; i < int'(NCH); i++) out_data_d[i] = {prefix, state[i]};
      out_valid_d = 1'b1;
    end else if (seed_wr || hs) begin
      // a seed write flushes any pending sample so the stream restarts cleanly
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      sample_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      sample_cnt_q <= sample_cnt_d;
    end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign sample_cnt = sample_cnt_q;
endmodule

// File: tb/tb_uniform_f32_multi_gen.sv
// Bench for uniform_f32_multi_gen: two instances (NCH=4/STEPS=1, NCH=3/STEPS=23) share stimulus
// and are compared each cycle against a transaction-level model of the sample stream.

module tb_uniform_f32_multi_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0, mode = 1'b0, seed_wr = 1'b0, out_ready = 1'b0;
  logic [2:0]  seed_ch = 3'd0;
  logic [22:0] seed_data = 23'd0;
  logic        ov0, ov1;
  logic [127:0] od0;
  logic [95:0]  od1;
  logic [31:0]  cnt0, cnt1;

  int nvec = 0, nfail = 0;

  always #5 clk = ~clk;

  uniform_f32_multi_gen #(.NCH(4), .STEPS(1)) dut (
    .clk(clk), .rst(rst), .run(run), .mode(mode), .seed_wr(seed_wr), .seed_ch(seed_ch),
    .seed_data(seed_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .sample_cnt(cnt0));

  uniform_f32_multi_gen #(.NCH(3), .STEPS(23)) dut23 (
    .clk(clk), .rst(rst), .run(run), .mode(mode), .seed_wr(seed_wr), .seed_ch(seed_ch),
    .seed_data(seed_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .sample_cnt(cnt1));

  // reference model: per instance, channel states, held sample, valid flag, accept count
  int unsigned m_s[2][8], m_d[2][8], m_c[2];
  bit          m_v[2];
  int unsigned nch[2] = '{4, 3};
  int unsigned stp[2] = '{1, 23};

  function automatic int unsigned lfsr_adv(input int unsigned s, input int unsigned n);
    for (int j = 0; j < int'(n); j++)
      s = ((s << 1) & 32'h7FFFFF) | (((s >> 22) ^ (s >> 17)) & 1);
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin m_s[k][i] = 1 << i; m_d[k][i] = 0; end
      m_v[k] = 0; m_c[k] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [255:0] odx;
    for (int k = 0; k < 2; k++) begin
      odx = (k == 0) ? 256'(od0) : 256'(od1);
      chk($sformatf("d%0d_valid", k), {31'd0, (k == 0) ? ov0 : ov1}, {31'd0, m_v[k]});
      chk($sformatf("d%0d_cnt", k), (k == 0) ? cnt0 : cnt1, m_c[k]);
      for (int i = 0; i < int'(nch[k]); i++)
        chk($sformatf("d%0d_ch%0d", k, i), odx[32*i +: 32], m_d[k][i]);
    end
  endtask

  task automatic cyc(input bit r, input bit md, input bit w, input logic [2:0] ch,
                     input logic [22:0] d, input bit rdy);
    bit ld, hs;
    run = r; mode = md; seed_wr = w; seed_ch = ch; seed_data = d; out_ready = rdy;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      ld = r && !w && (!m_v[k] || rdy);
      hs = m_v[k] && rdy;
      if (hs) m_c[k]++;
      if (ld) begin
        for (int i = 0; i < int'(nch[k]); i++) begin
          m_d[k][i] = (md ? 32'h0 : 32'h3F800000) | m_s[k][i];
          m_s[k][i] = lfsr_adv(m_s[k][i], stp[k]);
        end
        m_v[k] = 1;
      end else if (w) begin
        m_v[k] = 0;
        if (int'(ch) < int'(nch[k])) m_s[k][ch] = (d == 0) ? 1 : int'(d);
      end else if (hs) m_v[k] = 0;
    end
    #1 check_all();
  endtask

  initial begin
    int unsigned base;
    model_reset();
    #3 check_all();
    @(negedge clk) rst = 1'b0;

    // first samples after reset
    cyc(1, 0, 0, 0, 0, 1);
    chk("r31_ch0", od0[31:0],   32'h3F800001);
    chk("r31_ch1", od0[63:32],  32'h3F800002);
    chk("r31_ch2", od0[95:64],  32'h3F800004);
    chk("r31_ch3", od0[127:96], 32'h3F800008);
    cyc(1, 0, 0, 0, 0, 1);
    chk("r31_2nd", od0[31:0],   32'h3F800002);

    // seeded sequence on ch0
    cyc(1, 0, 1, 0, 23'h020000, 1);
    cyc(1, 0, 0, 0, 0, 1); chk("r32_a", od0[31:0] & 32'h7FFFFF, 32'h020000);
    cyc(1, 0, 0, 0, 0, 1); chk("r32_b", od0[31:0] & 32'h7FFFFF, 32'h040001);
    cyc(1, 0, 0, 0, 0, 1); chk("r32_c", od0[31:0] & 32'h7FFFFF, 32'h080002);

    // zero seed -> lock-up protection, pending sample flushed
    cyc(1, 0, 1, 1, 23'h0, 1);
    chk("r33_flush", {31'd0, ov0}, 32'd0);
    cyc(1, 0, 0, 0, 0, 1); chk("r33_ch1", od0[63:32] & 32'h7FFFFF, 32'h000001);

    // stall then drain three samples
    base = m_c[0];
    for (int j = 0; j < 5; j++) cyc(1, 0, 0, 0, 0, 0);
    chk("r34_stall_cnt", cnt0, base);
    for (int j = 0; j < 3; j++) cyc(1, 0, 0, 0, 0, 1);
    chk("r34_cnt", cnt0, base + 3);

    // out-of-range channel seed still flushes
    cyc(1, 0, 1, 3'd5, 23'h123456, 1);
    chk("r25_flush", {31'd0, ov1}, 32'd0);

    // STEPS=23 raw mantissa
    cyc(0, 1, 1, 0, 23'h000001, 1);
    cyc(1, 1, 0, 0, 0, 1); chk("r35_a", od1[31:0], 32'h00000001);
    cyc(1, 1, 0, 0, 0, 1); chk("r35_b", od1[31:0], lfsr_adv(1, 23));

    // randomized traffic
    for (int j = 0; j < 300; j++) begin
      logic [22:0] d;
      d = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
      cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
          3'($urandom_range(0, 7)), d, 1'($urandom));
    end

    // asynchronous reset during a stall
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    cyc(1, 0, 0, 0, 0, 1);
    chk("r36_ch0", od0[31:0],  32'h3F800001);
    chk("r36_ch3", od0[127:96], 32'h3F800008);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
